// File: rtl/mux_pkg.sv
// Shared types and reset constants for the N:1 scanning word multiplexer.
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_SCAN  = 2'b01,
        MODE_HOLD  = 2'b10
    } mux_mode_e;

    localparam logic       RST_VALID     = 1'b0;
    localparam logic       RST_WRAP      = 1'b0;
    localparam logic [1:0] RST_PREV_MODE = MODE_HOLD;

endpackage

// File: rtl/scan_ptr_ctr.sv
// Scan pointer with per-channel dwell counter; ptr is the channel to capture
// this cycle (already zeroed on restart), wrap flags the final cycle of a sweep.
module scan_ptr_ctr #(
    parameter  int N_CH  = 8,
    parameter  int DWELL = 4,
    localparam int SEL_W = $clog2(N_CH),
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             adv_en,
    output logic [SEL_W-1:0] ptr,
    output logic             wrap
);

    logic [SEL_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] w_dcnt_cur;
    logic             w_dwell_done;
    logic             w_last_ch;

    // Restart takes effect in the same cycle, so the entry cycle already counts as dwell 0 of channel 0.
    assign ptr          = restart ? '0 : r_ptr;
    assign w_dcnt_cur   = restart ? '0 : r_dcnt;
    assign w_dwell_done = (w_dcnt_cur == CNT_W'(DWELL - 1));
    assign w_last_ch    = (ptr == SEL_W'(N_CH - 1));
    assign wrap         = adv_en && w_dwell_done && w_last_ch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_dcnt <= '0;
        end else if (adv_en) begin
            if (w_dwell_done) begin
                r_dcnt <= '0;
                r_ptr  <= w_last_ch ? '0 : ptr + SEL_W'(1);
            end else begin
                r_dcnt <= w_dcnt_cur + CNT_W'(1);
                r_ptr  <= ptr;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N:1 word mux with fixed-select, auto-scan and hold modes.
module mux_nto1_scan
    import mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int W     = 8,
    parameter  int DWELL = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_CH*W-1:0] din,
    output logic [W-1:0]      dout,
    output logic [SEL_W-1:0]  dout_ch,
    output logic              dout_valid,
    output logic              scan_wrap
);

    logic [W-1:0]     r_dout;
    logic [SEL_W-1:0] r_dout_ch;
    logic             r_valid;
    logic             r_wrap;
    logic [1:0]       r_prev_mode;

    logic             w_is_scan;
    logic             w_restart;
    logic [SEL_W-1:0] w_ptr;
    logic             w_wrap;
    logic [SEL_W-1:0] w_idx;
    logic [W-1:0]     w_data;
    logic             w_legal;

    assign w_is_scan = (mode == MODE_SCAN);
    assign w_restart = (r_prev_mode != MODE_SCAN);

    scan_ptr_ctr #(
        .N_CH  (N_CH),
        .DWELL (DWELL)
    ) u_ptr (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .adv_en  (en && w_is_scan),
        .ptr     (w_ptr),
        .wrap    (w_wrap)
    );

    assign w_idx = w_is_scan ? w_ptr : sel;

    // Non-power-of-two N_CH leaves select codes with no channel; they read as 0 and are flagged illegal.
    always_comb begin
        w_data  = '0;
        w_legal = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_idx == SEL_W'(k)) begin
                w_data  = din[k*W +: W];
                w_legal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout      <= '0;
            r_dout_ch   <= '0;
            r_valid     <= RST_VALID;
            r_wrap      <= RST_WRAP;
            r_prev_mode <= RST_PREV_MODE;
        end else if (!en) begin
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_prev_mode <= mode;
            case (mode)
                MODE_FIXED: begin
                    r_dout    <= w_data;
                    r_dout_ch <= sel;
                    r_valid   <= w_legal;
                    r_wrap    <= 1'b0;
                end
                MODE_SCAN: begin
                    r_dout    <= w_data;
                    r_dout_ch <= w_ptr;
                    r_valid   <= 1'b1;
                    r_wrap    <= w_wrap;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_wrap  <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_ch    = r_dout_ch;
    assign dout_valid = r_valid;
    assign scan_wrap  = r_wrap;

endmodule
